// File: rtl/truth_table_sweeper.sv
// Truth-table equivalence sweeper: snapshots two N-input tables and walks
// every minterm, streaming both outputs and accumulating match statistics.
module truth_table_sweeper #(
    parameter int N                = 4,
    parameter bit STOP_ON_MISMATCH = 1'b0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [2**N-1:0] tt_a,
    input  logic [2**N-1:0] tt_b,
    output logic            busy,
    output logic            valid,
    output logic [N-1:0]    idx,
    output logic            sa,
    output logic            sb,
    output logic            mismatch,
    output logic [N:0]      ones_a,
    output logic [N:0]      ones_b,
    output logic [N:0]      err_cnt,
    output logic [N-1:0]    first_err,
    output logic            first_err_vld,
    output logic            done,
    output logic            equal,
    output logic            aborted
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SWEEP = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    localparam logic [N-1:0] LAST = {N{1'b1}};

    logic [1:0]      state_q, state_d;
    logic [N-1:0]    idx_q, idx_d;
    logic [2**N-1:0] snap_a_q, snap_a_d;
    logic [2**N-1:0] snap_b_q, snap_b_d;
    logic [N:0]      ones_a_q, ones_a_d;
    logic [N:0]      ones_b_q, ones_b_d;
    logic [N:0]      err_q, err_d;
    logic [N-1:0]    ferr_q, ferr_d;
    logic            ferr_vld_q, ferr_vld_d;
    logic            equal_q, equal_d;
    logic            aborted_q, aborted_d;

    logic sa_w, sb_w, sweep_w, mis_w;

    assign sweep_w = (state_q == S_SWEEP);
    assign sa_w    = snap_a_q[idx_q];
    assign sb_w    = snap_b_q[idx_q];
    assign mis_w   = sweep_w & (sa_w ^ sb_w);

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        snap_a_d   = snap_a_q;
        snap_b_d   = snap_b_q;
        ones_a_d   = ones_a_q;
        ones_b_d   = ones_b_q;
        err_d      = err_q;
        ferr_d     = ferr_q;
        ferr_vld_d = ferr_vld_q;
        equal_d    = equal_q;
        aborted_d  = aborted_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d    = S_SWEEP;
                    snap_a_d   = tt_a;
                    snap_b_d   = tt_b;
                    idx_d      = '0;
                    ones_a_d   = '0;
                    ones_b_d   = '0;
                    err_d      = '0;
                    ferr_d     = '0;
                    ferr_vld_d = 1'b0;
                    equal_d    = 1'b0;
                    aborted_d  = 1'b0;
                end
            end
            S_SWEEP: begin
                ones_a_d = ones_a_q + (N+1)'(sa_w);
                ones_b_d = ones_b_q + (N+1)'(sb_w);
                err_d    = err_q + (N+1)'(mis_w);
                if (mis_w && !ferr_vld_q) begin
                    ferr_d     = idx_q;
                    ferr_vld_d = 1'b1;
                end
                // Last minterm wins over abort so idx never wraps.
                if (idx_q == LAST) begin
                    state_d = S_DONE;
                end else if (STOP_ON_MISMATCH && mis_w) begin
                    state_d   = S_DONE;
                    aborted_d = 1'b1;
                end else begin
                    idx_d = idx_q + N'(1);
                end
            end
            S_DONE: begin
                equal_d = (err_q == '0) && !aborted_q;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            idx_q      <= '0;
            snap_a_q   <= '0;
            snap_b_q   <= '0;
            ones_a_q   <= '0;
            ones_b_q   <= '0;
            err_q      <= '0;
            ferr_q     <= '0;
            ferr_vld_q <= 1'b0;
            equal_q    <= 1'b0;
            aborted_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            snap_a_q   <= snap_a_d;
            snap_b_q   <= snap_b_d;
            ones_a_q   <= ones_a_d;
            ones_b_q   <= ones_b_d;
            err_q      <= err_d;
            ferr_q     <= ferr_d;
            ferr_vld_q <= ferr_vld_d;
            equal_q    <= equal_d;
            aborted_q  <= aborted_d;
        end
    end

    assign busy          = (state_q != S_IDLE);
    assign valid         = sweep_w;
    assign idx           = idx_q;
    assign sa            = sa_w;
    assign sb            = sb_w;
    assign mismatch      = mis_w;
    assign ones_a        = ones_a_q;
    assign ones_b        = ones_b_q;
    assign err_cnt       = err_q;
    assign first_err     = ferr_q;
    assign first_err_vld = ferr_vld_q;
    assign done          = (state_q == S_DONE);
    assign equal         = equal_q;
    assign aborted       = aborted_q;

endmodule
